// File: rtl/sipo_pack.sv
// sipo_pack: packs ratio_p consecutive width_p-bit beats from a valid/ready
// stream into one width_p*ratio_p-bit word. Lane order is little-endian
// (the first accepted beat lands in the low bits). One input beat per cycle
// is sustained while the consumer keeps ready_i high.
//
// Ports:
//   clk_i     - clock, all state updates on posedge
//   reset_ni  - asynchronous active-low reset
//   data_i    - input beat
//   valid_i   - input beat valid
//   ready_o   - block accepts a beat this cycle (combinational)
//   valid_o   - packed word valid (registered)
//   data_o    - packed word (registered)
//   ready_i   - consumer accepts the word this cycle
//
// Optional build macro SIPO_PACK_LAST_EN adds:
//   last_i    - accepted beat closes the word early
//   last_o    - word was closed by last_i
//   count_o   - number of valid lanes in data_o
module sipo_pack #(
   parameter int unsigned width_p = 8,
   parameter int unsigned ratio_p = 4
) (
   input  logic                         clk_i,
   input  logic                         reset_ni,
   input  logic [width_p-1:0]           data_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   output logic                         valid_o,
   output logic [width_p*ratio_p-1:0]   data_o,
   input  logic                         ready_i
`ifdef SIPO_PACK_LAST_EN
   ,
   input  logic                         last_i,
   output logic                         last_o,
   output logic [$clog2(ratio_p+1)-1:0] count_o
`endif
);

   localparam int unsigned CNT_W   = (ratio_p > 1) ? $clog2(ratio_p) : 1;
   localparam int unsigned OUT_W   = width_p * ratio_p;
   localparam int unsigned COUNT_W = $clog2(ratio_p + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ratio_p - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [OUT_W-1:0] data_r;
   logic [OUT_W-1:0] word_c;
   logic             valid_r;
   logic             last_c;
   logic             acc_in_c;
   logic             acc_out_c;
   logic             close_c;

`ifdef SIPO_PACK_LAST_EN
   assign last_c = last_i;
`else
   assign last_c = 1'b0;
`endif

   // Open lanes always accept; the closing beat needs an empty or draining output.
   assign ready_o   = ((cnt_r != CNT_MAX) & ~last_c) | ~valid_r | ready_i;
   assign acc_in_c  = valid_i & ready_o;
   assign acc_out_c = valid_r & ready_i;
   assign close_c   = acc_in_c & ((cnt_r == CNT_MAX) | last_c);

   generate
      if (ratio_p > 1) begin : g_coll
         logic [width_p-1:0] lane_r [ratio_p-1];

         // Collection buffer and beat counter.
         always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
               cnt_r <= '0;
               for (int k = 0; k < int'(ratio_p) - 1; k++) lane_r[k] <= '0;
            end else if (acc_in_c) begin
               if (close_c) begin
                  cnt_r <= '0;
               end else begin
                  for (int k = 0; k < int'(ratio_p) - 1; k++) begin
                     if (cnt_r == CNT_W'(k)) lane_r[k] <= data_i;
                  end
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
         end

         // Word as it would close this cycle: filled lanes, current beat, zeros above.
         always_comb begin
            word_c = '0;
            for (int k = 0; k < int'(ratio_p) - 1; k++) begin
               if (CNT_W'(k) < cnt_r)       word_c[k*width_p +: width_p] = lane_r[k];
               else if (CNT_W'(k) == cnt_r) word_c[k*width_p +: width_p] = data_i;
            end
            if (cnt_r == CNT_MAX) word_c[(ratio_p-1)*width_p +: width_p] = data_i;
         end
      end else begin : g_single
         assign cnt_r  = '0;
         assign word_c = data_i;
      end
   endgenerate

`ifdef SIPO_PACK_LAST_EN
   logic               last_r;
   logic [COUNT_W-1:0] count_r;
   assign last_o  = last_r;
   assign count_o = count_r;
`endif

   // Output register; a closing beat overrides a same-cycle drain (no bubble).
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         data_r  <= '0;
         valid_r <= 1'b0;
`ifdef SIPO_PACK_LAST_EN
         last_r  <= 1'b0;
         count_r <= '0;
`endif
      end else if (close_c) begin
         data_r  <= word_c;
         valid_r <= 1'b1;
`ifdef SIPO_PACK_LAST_EN
         last_r  <= last_c;
         count_r <= COUNT_W'(cnt_r) + COUNT_W'(1);
`endif
      end else if (acc_out_c) begin
         valid_r <= 1'b0;
      end
   end

   assign valid_o = valid_r;
   assign data_o  = data_r;

endmodule

// File: tb/tb_sipo_pack.sv
// Directed bench for sipo_pack: a ratio 4 instance and a ratio 1 instance.
module tb_sipo_pack;

   logic        clk = 1'b0;
   logic        rst_n;
   int          n_cmp = 0;
   int          n_bad = 0;

   // ratio_p = 4 instance
   logic [7:0]  a_data_i;
   logic        a_valid_i, a_ready_o, a_valid_o, a_ready_i;
   logic [31:0] a_data_o;
   // ratio_p = 1 instance
   logic [7:0]  b_data_i;
   logic        b_valid_i, b_ready_o, b_valid_o, b_ready_i;
   logic [7:0]  b_data_o;
`ifdef SIPO_PACK_LAST_EN
   logic        a_last_i, a_last_o, b_last_i, b_last_o;
   logic [2:0]  a_count_o;
   logic [0:0]  b_count_o;
`endif

   always #5 clk = ~clk;

   sipo_pack #(.width_p(8), .ratio_p(4)) dut_a (
      .clk_i(clk), .reset_ni(rst_n), .data_i(a_data_i), .valid_i(a_valid_i),
      .ready_o(a_ready_o), .valid_o(a_valid_o), .data_o(a_data_o), .ready_i(a_ready_i)
`ifdef SIPO_PACK_LAST_EN
      , .last_i(a_last_i), .last_o(a_last_o), .count_o(a_count_o)
`endif
   );

   sipo_pack #(.width_p(8), .ratio_p(1)) dut_b (
      .clk_i(clk), .reset_ni(rst_n), .data_i(b_data_i), .valid_i(b_valid_i),
      .ready_o(b_ready_o), .valid_o(b_valid_o), .data_o(b_data_o), .ready_i(b_ready_i)
`ifdef SIPO_PACK_LAST_EN
      , .last_i(b_last_i), .last_o(b_last_o), .count_o(b_count_o)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      a_data_i = '0; a_valid_i = 1'b0; a_ready_i = 1'b0;
      b_data_i = '0; b_valid_i = 1'b0; b_ready_i = 1'b0;
`ifdef SIPO_PACK_LAST_EN
      a_last_i = 1'b0; b_last_i = 1'b0;
`endif
      #12;
      chk("rst_valid", 32'(a_valid_o), 32'h0);
      chk("rst_data", a_data_o, 32'h0);
`ifdef SIPO_PACK_LAST_EN
      chk("rst_last", 32'(a_last_o), 32'h0);
      chk("rst_count", 32'(a_count_o), 32'h0);
`endif
      rst_n = 1'b1;
      #1;
      chk("rst_ready", 32'(a_ready_o), 32'h1);

      // Basic word 0x11..0x44
      a_ready_i = 1'b1;
      a_valid_i = 1'b1;
      a_data_i = 8'h11; tick();
      a_data_i = 8'h22; tick();
      a_data_i = 8'h33; tick();
      chk("basic_not_yet", 32'(a_valid_o), 32'h0);
      a_data_i = 8'h44; tick();
      chk("basic_valid", 32'(a_valid_o), 32'h1);
      chk("basic_data", a_data_o, 32'h44332211);
      a_valid_i = 1'b0; tick();
      chk("basic_pulse", 32'(a_valid_o), 32'h0);
      chk("basic_hold", a_data_o, 32'h44332211);

      // Back-to-back stream 0x01..0x08
      a_valid_i = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         a_data_i = 8'(i);
         #1;
         chk("stream_ready", 32'(a_ready_o), 32'h1);
         tick();
         chk("stream_valid", 32'(a_valid_o), (i == 4 || i == 8) ? 32'h1 : 32'h0);
         if (i == 4) chk("stream_w0", a_data_o, 32'h04030201);
         if (i == 8) chk("stream_w1", a_data_o, 32'h08070605);
      end
      a_valid_i = 1'b0; tick();
      chk("stream_drain", 32'(a_valid_o), 32'h0);

      // Backpressure
      a_valid_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         a_data_i = 8'(i); tick();
      end
      chk("bp_w0_valid", 32'(a_valid_o), 32'h1);
      a_ready_i = 1'b0;
      for (int i = 5; i <= 7; i++) begin
         a_data_i = 8'(i);
         #1;
         chk("bp_open_ready", 32'(a_ready_o), 32'h1);
         tick();
         chk("bp_stable_valid", 32'(a_valid_o), 32'h1);
         chk("bp_stable_data", a_data_o, 32'h04030201);
      end
      a_data_i = 8'h08;
      #1;
      chk("bp_close_blocked", 32'(a_ready_o), 32'h0);
      tick();
      chk("bp_hold_valid", 32'(a_valid_o), 32'h1);
      chk("bp_hold_data", a_data_o, 32'h04030201);
      a_ready_i = 1'b1;
      #1;
      chk("bp_release_ready", 32'(a_ready_o), 32'h1);
      tick();
      chk("bp_w1_valid", 32'(a_valid_o), 32'h1);
      chk("bp_w1_data", a_data_o, 32'h08070605);
      a_valid_i = 1'b0; tick();
      chk("bp_drain", 32'(a_valid_o), 32'h0);

      // Reset mid-word with a pending output word
      a_ready_i = 1'b0;
      a_valid_i = 1'b1;
      a_data_i = 8'h10; tick();
      a_data_i = 8'h20; tick();
      a_data_i = 8'h30; tick();
      a_data_i = 8'h40; tick();
      chk("rstm_pending", a_data_o, 32'h40302010);
      a_data_i = 8'hAA; tick();
      a_data_i = 8'hBB; tick();
      a_valid_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rstm_valid", 32'(a_valid_o), 32'h0);
      chk("rstm_data", a_data_o, 32'h0);
      #1 rst_n = 1'b1;
      a_ready_i = 1'b1;
      tick();
      a_valid_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         a_data_i = 8'(i); tick();
      end
      chk("rstm_word_valid", 32'(a_valid_o), 32'h1);
      chk("rstm_word_data", a_data_o, 32'h04030201);
      a_valid_i = 1'b0; tick();

      // ratio_p = 1: single elastic register
      b_ready_i = 1'b1;
      b_valid_i = 1'b1;
      b_data_i = 8'h5A; tick();
      chk("r1_valid", 32'(b_valid_o), 32'h1);
      chk("r1_data", 32'(b_data_o), 32'h5A);
      b_ready_i = 1'b0;
      b_data_i = 8'h6B;
      #1;
      chk("r1_stall_ready", 32'(b_ready_o), 32'h0);
      tick();
      chk("r1_stall_data", 32'(b_data_o), 32'h5A);
      chk("r1_stall_valid", 32'(b_valid_o), 32'h1);
      b_ready_i = 1'b1;
      #1;
      chk("r1_go_ready", 32'(b_ready_o), 32'h1);
      tick();
      chk("r1_next", 32'(b_data_o), 32'h6B);
      b_data_i = 8'h7C; tick();
      chk("r1_thru", 32'(b_data_o), 32'h7C);
      chk("r1_thru_valid", 32'(b_valid_o), 32'h1);
      b_valid_i = 1'b0; tick();
      chk("r1_drain", 32'(b_valid_o), 32'h0);

`ifdef SIPO_PACK_LAST_EN
      // Early close with last_i
      a_ready_i = 1'b1;
      a_valid_i = 1'b1;
      a_data_i = 8'h11; a_last_i = 1'b0; tick();
      a_data_i = 8'h22; a_last_i = 1'b1; tick();
      chk("last_data", a_data_o, 32'h00002211);
      chk("last_count", 32'(a_count_o), 32'h2);
      chk("last_flag", 32'(a_last_o), 32'h1);
      a_last_i = 1'b0;
      for (int i = 3; i <= 6; i++) begin
         a_data_i = 8'(i * 8'h11); tick();
      end
      chk("last_full_data", a_data_o, 32'h66554433);
      chk("last_full_count", 32'(a_count_o), 32'h4);
      chk("last_full_flag", 32'(a_last_o), 32'h0);
      a_valid_i = 1'b0; tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
